// File: rtl/mem_io_responder_if.sv
// Byte-wide memory bus plus host-link TX/RX byte streams.
// The responder takes the slave view; the CPU side and host take master.
interface mem_io_responder_if;
    logic        mem_wr_i;
    logic [31:0] mem_a_i;
    logic [7:0]  mem_dout_i;
    logic [7:0]  mem_din_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        tx_full_o;
    logic        sim_end_o;

    modport slave (
        input  mem_wr_i, mem_a_i, mem_dout_i,
        input  tx_ready_i, rx_data_i, rx_valid_i,
        output mem_din_o, tx_data_o, tx_valid_o,
        output rx_ready_o, tx_full_o, sim_end_o
    );

    modport master (
        output mem_wr_i, mem_a_i, mem_dout_i,
        output tx_ready_i, rx_data_i, rx_valid_i,
        input  mem_din_o, tx_data_o, tx_valid_o,
        input  rx_ready_o, tx_full_o, sim_end_o
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-bus responder: byte RAM, TX/RX byte FIFOs, status and halt port.
// Reads return one edge after the address is presented.

module mem_io_fifo #(
    parameter int AW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == {1'b1, {AW{1'b0}}});
    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a push on full needs.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = mem_q[rp_q];

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
        if (!push_ok && pop_ok) cnt_d = cnt_q - 1'b1;
    end

    // Pointers and count; reset discards contents at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wp_q <= wp_q + 1'b1;
            if (pop_ok)  rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset; only written slots are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q] <= data_i;
    end
endmodule

module mem_io_responder #(
    parameter int RAM_AW  = 17,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    mem_io_responder_if.slave  bus
);
    localparam logic [17:0] IO_DATA = 18'h30000;
    localparam logic [17:0] IO_STAT = 18'h30004;

    logic [7:0]        ram_q [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    logic [7:0]        mem_din_q, mem_din_d;
    logic              last_rx_q, ovf_q, sim_end_q;
    logic              is_io, data_hit, stat_hit, wr;
    logic              rx_rd, stat_rd, tx_wr, stat_wr, ram_wr;
    logic              tx_full, tx_empty, tx_pop, tx_drop;
    logic              rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]        rx_head;
    logic              unused_hi;

    assign wr       = bus.mem_wr_i;
    assign is_io    = (bus.mem_a_i[17:16] == 2'b11);
    assign data_hit = (bus.mem_a_i[17:0] == IO_DATA);
    assign stat_hit = (bus.mem_a_i[17:0] == IO_STAT);
    assign ram_idx  = bus.mem_a_i[RAM_AW-1:0];
    assign unused_hi = ^bus.mem_a_i[31:18];

    assign rx_rd   = !wr && data_hit;
    assign stat_rd = !wr && stat_hit;
    assign tx_wr   = wr && data_hit;
    assign stat_wr = wr && stat_hit;
    assign ram_wr  = wr && !is_io;

    assign tx_pop  = !tx_empty && bus.tx_ready_i;
    assign tx_drop = tx_wr && tx_full && !tx_pop;
    assign rx_push = bus.rx_valid_i && !rx_full;
    // A held read address pops only on its first cycle.
    assign rx_pop  = rx_rd && !last_rx_q && !rx_empty;

    mem_io_fifo #(.AW(FIFO_AW)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_wr),
        .pop_i   (tx_pop),
        .data_i  (bus.mem_dout_i),
        .data_o  (bus.tx_data_o),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    mem_io_fifo #(.AW(FIFO_AW)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .data_i  (bus.rx_data_i),
        .data_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign bus.tx_valid_o = !tx_empty;
    assign bus.rx_ready_o = !rx_full;
    assign bus.tx_full_o  = tx_full;
    assign bus.sim_end_o  = sim_end_q;
    assign bus.mem_din_o  = mem_din_q;

    // Select the byte returned on the next edge.
    always_comb begin
        mem_din_d = ram_q[ram_idx];
        if (wr) begin
            mem_din_d = 8'h00;
        end else if (rx_rd) begin
            if (last_rx_q)     mem_din_d = mem_din_q;
            else if (rx_empty) mem_din_d = 8'h00;
            else               mem_din_d = rx_head;
        end else if (stat_rd) begin
            mem_din_d = {5'b0, ovf_q, !rx_empty, tx_full};
        end else if (is_io) begin
            mem_din_d = 8'h00;
        end
    end

    // Read data, RX de-dup flag, sticky overflow and halt pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_din_q <= 8'h00;
            last_rx_q <= 1'b0;
            ovf_q     <= 1'b0;
            sim_end_q <= 1'b0;
        end else begin
            mem_din_q <= mem_din_d;
            last_rx_q <= rx_rd;
            ovf_q     <= ovf_q | tx_drop;
            sim_end_q <= stat_wr;
        end
    end

    // Byte RAM, contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_wr) ram_q[ram_idx] <= bus.mem_dout_i;
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with queue scoreboards
// for read data and TX bytes.
module tb_mem_io_responder;
    logic clk = 1'b0;
    logic rst;
    logic chk_rd;
    int   n_tot = 0;
    int   n_pass = 0;
    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];

    mem_io_responder_if bus();

    mem_io_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic miss(input string name);
        n_tot++;
        $display("FAIL %s: got nothing expected an entry", name);
    endtask

    // One bus cycle; entered and left at posedge+1.
    task automatic cyc(input logic wr, input logic [31:0] a,
                       input logic [7:0] d, input bit chk,
                       input logic [7:0] exp);
        bus.mem_wr_i   = wr;
        bus.mem_a_i    = a;
        bus.mem_dout_i = d;
        chk_rd = chk;
        if (chk) rd_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.mem_wr_i = 1'b0;
        bus.mem_a_i  = 32'h0;
        chk_rd = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_tx_valid", bus.tx_valid_o, 0);
        check("rst_rx_ready", bus.rx_ready_o, 1);
        check("rst_tx_full", bus.tx_full_o, 0);
        check("rst_mem_din", bus.mem_din_o, 0);
        tx_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares read data and TX bytes against the queues.
    initial begin
        bit pend;
        forever begin
            @(posedge clk);
            pend = chk_rd;
            @(negedge clk);
            if (pend) begin
                if (rd_q.size() == 0) miss("rd_q");
                else check("mem_din", bus.mem_din_o, rd_q.pop_front());
            end
            if (bus.tx_valid_o && bus.tx_ready_i) begin
                if (tx_q.size() == 0) miss("tx_q");
                else check("tx_data", bus.tx_data_o, tx_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] word;
        logic [7:0]  b;
        rst = 1'b1;
        chk_rd = 1'b0;
        bus.mem_wr_i = 1'b0;
        bus.mem_a_i = 32'h0;
        bus.mem_dout_i = 8'h00;
        bus.tx_ready_i = 1'b0;
        bus.rx_data_i = 8'h00;
        bus.rx_valid_i = 1'b0;
        @(posedge clk);
        #1;
        check("reset_din", bus.mem_din_o, 0);
        check("reset_sim_end", bus.sim_end_o, 0);
        check("reset_tx_valid", bus.tx_valid_o, 0);
        check("reset_rx_ready", bus.rx_ready_o, 1);
        check("reset_tx_full", bus.tx_full_o, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // RAM byte, write then held read
        cyc(1'b1, 32'h10, 8'h5A, 1'b1, 8'h00);
        cyc(1'b0, 32'h10, 8'h00, 1'b1, 8'h5A);
        cyc(1'b0, 32'h10, 8'h00, 1'b1, 8'h5A);

        // Word as four bytes, then alias through bit 17
        word = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'h100 + i, word[8*i +: 8], 1'b0, 8'h00);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 32'h100 + i, 8'h00, 1'b1, word[8*i +: 8]);
        cyc(1'b1, 32'h20100, 8'h77, 1'b0, 8'h00);
        cyc(1'b0, 32'h100, 8'h00, 1'b1, 8'h77);

        // TX fill, overflow drop, drain
        for (int i = 0; i < 8; i++) begin
            b = 8'h41 + 8'(i);
            tx_q.push_back(b);
            cyc(1'b1, 32'h30000, b, 1'b0, 8'h00);
        end
        check("tx_full_8", bus.tx_full_o, 1);
        check("tx_head", bus.tx_data_o, 8'h41);
        cyc(1'b1, 32'h30000, 8'h49, 1'b0, 8'h00);
        cyc(1'b0, 32'h30004, 8'h00, 1'b1, 8'h05);
        bus.tx_ready_i = 1'b1;
        repeat (8) idle();
        bus.tx_ready_i = 1'b0;
        check("tx_drained", bus.tx_valid_o, 0);
        check("tx_not_full", bus.tx_full_o, 0);

        // RX with held read address
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i = 8'h10;
        idle();
        bus.rx_data_i = 8'h11;
        idle();
        bus.rx_valid_i = 1'b0;
        cyc(1'b0, 32'h30004, 8'h00, 1'b1, 8'h06);
        cyc(1'b0, 32'h30000, 8'h00, 1'b1, 8'h10);
        cyc(1'b0, 32'h30000, 8'h00, 1'b1, 8'h10);
        idle();
        cyc(1'b0, 32'h30000, 8'h00, 1'b1, 8'h11);
        idle();
        cyc(1'b0, 32'h30000, 8'h00, 1'b1, 8'h00);
        cyc(1'b0, 32'h30004, 8'h00, 1'b1, 8'h04);
        cyc(1'b0, 32'h30008, 8'h00, 1'b1, 8'h00);

        // Push on full with simultaneous pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            b = 8'h80 + 8'(i);
            tx_q.push_back(b);
            cyc(1'b1, 32'h30000, b, 1'b0, 8'h00);
        end
        bus.tx_ready_i = 1'b1;
        tx_q.push_back(8'h99);
        cyc(1'b1, 32'h30000, 8'h99, 1'b0, 8'h00);
        bus.tx_ready_i = 1'b0;
        check("tx_full_kept", bus.tx_full_o, 1);
        cyc(1'b0, 32'h30004, 8'h00, 1'b1, 8'h01);
        bus.tx_ready_i = 1'b1;
        repeat (8) idle();
        bus.tx_ready_i = 1'b0;
        check("tx_drained2", bus.tx_valid_o, 0);

        // Pointer wrap through 20 push/pop pairs
        bus.tx_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = 8'hC0 + 8'(i);
            tx_q.push_back(b);
            cyc(1'b1, 32'h30000, b, 1'b0, 8'h00);
        end
        idle();
        bus.tx_ready_i = 1'b0;
        check("wrap_empty", bus.tx_valid_o, 0);

        // Async reset with traffic in both FIFOs
        for (int i = 0; i < 3; i++) begin
            b = 8'hA0 + 8'(i);
            tx_q.push_back(b);
            cyc(1'b1, 32'h30000, b, 1'b0, 8'h00);
        end
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i = 8'h21;
        idle();
        bus.rx_data_i = 8'h22;
        idle();
        bus.rx_valid_i = 1'b0;
        cyc(1'b0, 32'h30004, 8'h00, 1'b1, 8'h02);
        check("pre_rst_tx_valid", bus.tx_valid_o, 1);
        cyc(1'b0, 32'h10, 8'h00, 1'b0, 8'h00);
        check("pre_rst_din", bus.mem_din_o, 8'h5A);
        do_reset();
        cyc(1'b0, 32'h30004, 8'h00, 1'b1, 8'h00);
        check("sim_end_idle", bus.sim_end_o, 0);
        cyc(1'b1, 32'h30004, 8'h00, 1'b0, 8'h00);
        check("sim_end_pulse", bus.sim_end_o, 1);
        idle();
        check("sim_end_drop", bus.sim_end_o, 0);

        idle();
        check("rd_q_left", rd_q.size(), 0);
        check("tx_q_left", tx_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
